// File: rtl/key_event_decoder_pkg.sv
// Shared types and constants for the key event decoder.
// Build option KEY_REPEAT_EN (used by the FSM and top) enables auto-repeat pulses.
package key_event_pkg;

  typedef enum logic [1:0] {
    WAIT_REL = 2'd0,
    IDLE     = 2'd1,
    PRESS    = 2'd2,
    LONG     = 2'd3
  } key_state_e;

  // Debounced key level that means "pressed" (keys are active-low).
  localparam logic KEY_PRESSED = 1'b0;

  // Number of clk cycles per 1 ms tick.
  function automatic int unsigned tick_div(input int unsigned clk_hz);
    return clk_hz / 1000;
  endfunction

endpackage

// File: rtl/key_event_decoder_fsm.sv
// Per-key classifier: turns one registered key level into short/long/repeat
// pulses and a held level. Auto-repeat is built only when KEY_REPEAT_EN is defined.
module key_event_fsm
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic ms_tick,
  input  logic key_q,
  output logic key_short,
  output logic key_long,
  output logic key_repeat,
  output logic key_held
);

  localparam int unsigned HOLD_W = (LONG_MS > 1) ? $clog2(LONG_MS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_MS - 1);

  if (LONG_MS < 1 || REPEAT_MS < 1) begin : g_bad_param
    $error("key_event_fsm: LONG_MS and REPEAT_MS must be at least 1");
  end

  key_state_e        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              short_d, long_d, held_d;

`ifdef KEY_REPEAT_EN
  localparam int unsigned REP_W = (REPEAT_MS > 1) ? $clog2(REPEAT_MS) : 1;
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_MS - 1);

  logic [REP_W-1:0] rep_q, rep_d;
  logic             repeat_d;
`endif

  // Next-state, counter and pulse decode; release always takes priority over a tick.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    short_d = 1'b0;
    long_d  = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d    = rep_q;
    repeat_d = 1'b0;
`endif
    case (state_q)
      WAIT_REL: begin
        if (key_q != KEY_PRESSED) state_d = IDLE;
      end
      IDLE: begin
        if (key_q == KEY_PRESSED) begin
          state_d = PRESS;
          hold_d  = '0;
        end
      end
      PRESS: begin
        if (key_q != KEY_PRESSED) begin
          state_d = IDLE;
          short_d = 1'b1;
        end else if (ms_tick) begin
          if (hold_q == HOLD_MAX) begin
            state_d = LONG;
            long_d  = 1'b1;
`ifdef KEY_REPEAT_EN
            rep_d   = '0;
`endif
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
      end
      LONG: begin
        if (key_q != KEY_PRESSED) begin
          state_d = IDLE;
        end
`ifdef KEY_REPEAT_EN
        else if (ms_tick) begin
          if (rep_q == REP_MAX) begin
            repeat_d = 1'b1;
            rep_d    = '0;
          end else begin
            rep_d = rep_q + REP_W'(1);
          end
        end
`endif
      end
      default: state_d = WAIT_REL;
    endcase
    held_d = (state_d == PRESS) || (state_d == LONG);
  end

  // State, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= WAIT_REL;
      hold_q    <= '0;
      key_short <= 1'b0;
      key_long  <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      key_short <= short_d;
      key_long  <= long_d;
      key_held  <= held_d;
    end
  end

`ifdef KEY_REPEAT_EN
  // Repeat counter and registered repeat pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_q      <= '0;
      key_repeat <= 1'b0;
    end else begin
      rep_q      <= rep_d;
      key_repeat <= repeat_d;
    end
  end
`else
  assign key_repeat = 1'b0;
`endif

endmodule

// File: rtl/key_event_decoder.sv
// Key event decoder top: shared 1 ms timebase, input register and one
// classifier FSM per key. Define KEY_REPEAT_EN to build auto-repeat pulses.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int unsigned NUM_KEYS  = 3,
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_short,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [NUM_KEYS-1:0] key_repeat,
  output logic [NUM_KEYS-1:0] key_held
);

  localparam int unsigned TICK_DIV = tick_div(CLK_HZ);
  localparam int unsigned TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_clk
    $error("key_event_decoder: CLK_HZ must be at least 1000");
  end

  logic [TICK_W-1:0]   tick_cnt;
  logic                ms_tick;
  logic [NUM_KEYS-1:0] key_q;

  assign ms_tick = (tick_cnt == TICK_MAX);

  // 1 ms timebase: counts 0..TICK_DIV-1 and wraps.
  always_ff @(posedge clk) begin
    if (rst || ms_tick) tick_cnt <= '0;
    else                tick_cnt <= tick_cnt + TICK_W'(1);
  end

  // Input register; left free-running through reset so the FSMs see the real
  // key level straight after reset and a key held through reset stays in WAIT_REL.
  always_ff @(posedge clk) begin
    key_q <= key_level;
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_event_fsm #(
      .LONG_MS   (LONG_MS),
      .REPEAT_MS (REPEAT_MS)
    ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .ms_tick    (ms_tick),
      .key_q      (key_q[k]),
      .key_short  (key_short[k]),
      .key_long   (key_long[k]),
      .key_repeat (key_repeat[k]),
      .key_held   (key_held[k])
    );
  end

endmodule
